// File: rtl/enet_tx_packetizer.sv
// Drains a standard (read latency 1) TX FIFO into the MAC AXI-stream TX port,
// framing by runtime length or idle timeout, zero-padding short frames and spacing frames by a gap.
module enet_tx_packetizer #(
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 11,
   parameter int CNT_W      = 14,
   parameter int MAX_BEATS  = 1024,
   parameter int MIN_BEATS  = 46,
   parameter int TIMEOUT    = 4096,
   parameter int GAP_CYCLES = 12
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic [LEN_W-1:0]  i_pkt_len,
   input  logic [CNT_W-1:0]  i_fifo_count,
   output logic              o_fifo_rd_en,
   input  logic [DATA_W-1:0] i_fifo_dout,
   output logic [DATA_W-1:0] o_axi_tx_tdata,
   output logic              o_axi_tx_tvalid,
   input  logic              i_axi_tx_tready,
   output logic              o_axi_tx_tlast,
   output logic [31:0]       o_pkt_count,
   output logic              o_busy
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_PAD,
      ST_GAP
   } state_t;

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   eff_len;
   logic [LEN_W-1:0]   start_len;
   logic [LEN_W-1:0]   rd_left;
   logic [LEN_W-1:0]   data_left;
   logic [LEN_W-1:0]   pad_left;
   logic [TMR_W-1:0]   idle_timer;
   logic [GAP_W-1:0]   gap_cnt;
   logic [DATA_W-1:0]  skid0, skid1;
   logic [1:0]         skid_occ;
   logic               rd_pend;
   logic               start_full, start_flush, start;
   logic               beat_hs, data_hs, skid_push, skid_pop;

   always_comb begin
      if (i_pkt_len == '0 || i_pkt_len > LEN_W'(MAX_BEATS)) eff_len = LEN_W'(MAX_BEATS);
      else                                                  eff_len = i_pkt_len;
   end

   assign start_full  = (state == ST_IDLE) && i_enable && (i_fifo_count >= CNT_W'(eff_len));
   assign start_flush = (state == ST_IDLE) && i_enable && (i_fifo_count != '0) &&
                        (idle_timer == TMR_W'(TIMEOUT - 1));
   assign start       = start_full || start_flush;
   // A flush only fires when the count is below eff_len, so it fits in LEN_W bits.
   assign start_len   = start_full ? eff_len : i_fifo_count[LEN_W-1:0];

   assign beat_hs   = o_axi_tx_tvalid && i_axi_tx_tready;
   assign data_hs   = beat_hs && (state == ST_SEND);
   // Data returning from the FIFO bypasses an empty skid buffer; it is stored only if not taken at once.
   assign skid_pop  = data_hs && (skid_occ != 2'd0);
   assign skid_push = rd_pend && !(data_hs && (skid_occ == 2'd0));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt       = state;
      o_fifo_rd_en    = 1'b0;
      o_axi_tx_tvalid = 1'b0;
      o_axi_tx_tdata  = '0;
      o_axi_tx_tlast  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_SEND;
         end
         ST_SEND: begin
            o_fifo_rd_en    = (rd_left != '0) && ((skid_occ + {1'b0, rd_pend}) < 2'd2);
            o_axi_tx_tvalid = (skid_occ != 2'd0) || rd_pend;
            o_axi_tx_tdata  = (skid_occ != 2'd0) ? skid0 : i_fifo_dout;
            o_axi_tx_tlast  = o_axi_tx_tvalid && (data_left == LEN_W'(1)) && (pad_left == '0);
            if (data_hs && data_left == LEN_W'(1))
               state_nxt = (pad_left != '0) ? ST_PAD : ST_GAP;
         end
         ST_PAD: begin
            o_axi_tx_tvalid = 1'b1;
            o_axi_tx_tlast  = (pad_left == LEN_W'(1));
            if (i_axi_tx_tready && pad_left == LEN_W'(1)) state_nxt = ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign o_busy = (state != ST_IDLE);

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_left   <= '0;
         data_left <= '0;
         pad_left  <= '0;
      end else if (start) begin
         rd_left   <= start_len;
         data_left <= start_len;
         pad_left  <= (start_len < LEN_W'(MIN_BEATS)) ? LEN_W'(MIN_BEATS) - start_len : '0;
      end else begin
         if (o_fifo_rd_en)                   rd_left   <= rd_left - LEN_W'(1);
         if (data_hs)                        data_left <= data_left - LEN_W'(1);
         if (beat_hs && (state == ST_PAD))   pad_left  <= pad_left - LEN_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idle_timer <= '0;
         gap_cnt    <= '0;
      end else begin
         if ((state == ST_IDLE) && !start && i_enable && (i_fifo_count != '0) &&
             (i_fifo_count < CNT_W'(eff_len)))
            idle_timer <= idle_timer + TMR_W'(1);
         else
            idle_timer <= '0;
         if ((state == ST_GAP) && (state_nxt == ST_GAP)) gap_cnt <= gap_cnt + GAP_W'(1);
         else                                            gap_cnt <= '0;
      end
   end

   // NOTE: the two skid data registers are reset as well; they are plain flops, not a RAM.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_pend  <= 1'b0;
         skid_occ <= 2'd0;
         skid0    <= '0;
         skid1    <= '0;
      end else begin
         rd_pend <= o_fifo_rd_en;
         case ({skid_push, skid_pop})
            2'b10: begin
               if (skid_occ == 2'd0) skid0 <= i_fifo_dout;
               else                  skid1 <= i_fifo_dout;
               skid_occ <= skid_occ + 2'd1;
            end
            2'b01: begin
               skid0    <= skid1;
               skid_occ <= skid_occ - 2'd1;
            end
            2'b11: begin
               if (skid_occ == 2'd1) begin
                  skid0 <= i_fifo_dout;
               end else begin
                  skid0 <= skid1;
                  skid1 <= i_fifo_dout;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                      o_pkt_count <= '0;
      else if (beat_hs && o_axi_tx_tlast) o_pkt_count <= o_pkt_count + 32'd1;
   end

endmodule
